mem_stream_reader: RTL and testbench

//  Initiator for the 64-bit req/we/be/addr/rdata scratch-RAM port, which returns read data exactly 1 cycle after req.

---
 rtl/mem_stream_reader.sv | 163 ++++++++++++++++
 tb/tb_mem_stream_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// Streams SIZE consecutive 64-bit words from a 1-cycle-latency scratch RAM port into a valid/ready FIFO.
// Optional MEM_STREAM_PERF_CNT_EN adds stall_cycles_o (cycles with valid_o & !ready_i).
module mem_stream_reader #(
  parameter int FIFO_DEPTH = 2,
  parameter int SIZE_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [63:0]       base_addr_i,
  input  logic [SIZE_W-1:0] size_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              req_o,
  output logic              we_o,
  output logic [7:0]        be_o,
  output logic [63:0]       addr_o,
  input  logic [63:0]       rdata_i,
  output logic [63:0]       data_o,
  output logic              valid_o,
  input  logic              ready_i
`ifdef MEM_STREAM_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [SIZE_W-1:0] remaining_q, remaining_d;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              req;

  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;
  logic [CW:0]       occupancy, limit;

  assign push      = inflight_q;
  assign valid_o   = (count_q != '0);
  assign pop       = valid_o & ready_i;
  assign data_o    = valid_o ? fifo_mem[rd_ptr_q] : 64'd0;
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  // A word leaving the FIFO this cycle frees a slot in time for the return of a request issued now.
  assign limit     = DEPTH_V + {{CW{1'b0}}, pop};

  assign req_o  = req;
  assign addr_o = addr_q;
  assign we_o   = 1'b0;
  assign be_o   = 8'hFF;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    req         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (size_i != '0) begin
            state_d     = RUN;
            addr_d      = {base_addr_i[63:3], 3'b000};
            remaining_d = size_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if ((remaining_q != '0) && (occupancy < limit)) begin
          req         = 1'b1;
          addr_d      = addr_q + 64'd8;
          remaining_d = remaining_q - SIZE_W'(1);
          if (remaining_q == SIZE_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (count_q == CW'(1)) && pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= 64'd0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= req;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: data_o is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= rdata_i;
    end
  end

`ifdef MEM_STREAM_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= 32'd0;
    end else if ((state_q == IDLE) && start_i) begin
      stall_q <= 32'd0;
    end else if (valid_o && !ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: vector table plus hand sequences, scoreboarded address and data.
module tb_mem_stream_reader;

  localparam int SIZE_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [63:0]       base_addr_i = 64'd0;
  logic [SIZE_W-1:0] size_i = '0;
  logic              busy_o, done_o, req_o, we_o, valid_o;
  logic [7:0]        be_o;
  logic [63:0]       addr_o, data_o;
  logic [63:0]       rdata_i = 64'd0;
  logic              ready_i = 1'b0;
`ifdef MEM_STREAM_PERF_CNT_EN
  logic [31:0]       stall_cycles_o;
`endif

  mem_stream_reader #(.FIFO_DEPTH(2), .SIZE_W(SIZE_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .size_i      (size_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .req_o       (req_o),
    .we_o        (we_o),
    .be_o        (be_o),
    .addr_o      (addr_o),
    .rdata_i     (rdata_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
`ifdef MEM_STREAM_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] base;
    int unsigned size;
    int          mode;
    logic [63:0] exp_first;
    int          exp_words;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_addr_q [$];
  logic [63:0] exp_data_q [$];

  int   ready_mode = 0;
  logic ready_manual = 1'b0;

  int          words_seen, reqs_seen, done_cnt;
  int          first_req_cyc, last_req_cyc, first_valid_cyc, last_hs_cyc, done_cyc, start_cyc;
  logic        busy_seen;
  logic [63:0] first_addr;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scratch RAM model: data for the requested address appears one cycle after req_o.
  always @(posedge clk_i) begin
    cyc     <= cyc + 1;
    rdata_i <= req_o ? mem_word(addr_o) : 64'hDEAD_BEEF_0BAD_F00D;
  end

  always @(posedge clk_i) begin
    #1;
    case (ready_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = ~ready_i;
      2:       ready_i = 1'($urandom_range(0, 1));
      default: ready_i = ready_manual;
    endcase
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (busy_o) busy_seen = 1'b1;
      if (req_o) begin
        reqs_seen++;
        if (reqs_seen == 1) begin
          first_req_cyc = cyc;
          first_addr    = addr_o;
        end
        last_req_cyc = cyc;
        if (exp_addr_q.size() == 0) begin
          checkOutput("unexpected_req", 64'd1, 64'd0);
        end else begin
          checkOutput("addr", addr_o, exp_addr_q.pop_front());
        end
        checkOutput("we_be", 64'({we_o, be_o}), 64'h0FF);
      end
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(valid_o), 64'd1);
        checkOutput("hold_data", data_o, prev_data);
      end
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o && ready_i) begin
        words_seen++;
        last_hs_cyc = cyc;
        if (exp_data_q.size() == 0) begin
          checkOutput("extra_word", 64'd1, 64'd0);
        end else begin
          checkOutput("data", data_o, exp_data_q.pop_front());
        end
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
    end
  end

  task automatic applyStimulus(input logic [63:0] base, input int unsigned size, input int mode);
    logic [63:0] a;
    words_seen = 0; reqs_seen = 0; done_cnt = 0; busy_seen = 1'b0;
    first_req_cyc = -1; last_req_cyc = -1; first_valid_cyc = -1;
    last_hs_cyc = -1; done_cyc = -1; first_addr = 64'd0;
    a = {base[63:3], 3'b000};
    for (int unsigned k = 0; k < size; k++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
      a = a + 64'd8;
    end
    @(posedge clk_i);
    #2;
    ready_mode  = mode;
    base_addr_i = base;
    size_i      = size;
    start_i     = 1'b1;
    @(posedge clk_i);
    #2;
    start_cyc = cyc;
    start_i   = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    repeat (3) @(posedge clk_i);
    #2;
  endtask

  task automatic checkReset();
    checkOutput("rst_ctrl", 64'({busy_o, done_o, req_o, valid_o}), 64'd0);
    checkOutput("rst_addr", addr_o, 64'd0);
    checkOutput("rst_data", data_o, 64'd0);
`ifdef MEM_STREAM_PERF_CNT_EN
    checkOutput("rst_stall", 64'(stall_cycles_o), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{64'h100, 4, 0, 64'h100, 4};
    vecs[1] = '{64'h207, 3, 0, 64'h200, 3};
    vecs[2] = '{64'h1000, 8, 1, 64'h1000, 8};
    vecs[3] = '{64'h2000, 0, 0, 64'h0, 0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFF0, 4, 0, 64'hFFFF_FFFF_FFFF_FFF0, 4};
    vecs[5] = '{64'h3000, 10, 2, 64'h3000, 10};
    vecs[6] = '{64'h45, 1, 0, 64'h40, 1};

    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    checkReset();
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].base, vecs[i].size, vecs[i].mode);
      waitDone(400);
      checkOutput("done_pulses", 64'(done_cnt), 64'd1);
      checkOutput("word_count", 64'(words_seen), 64'(vecs[i].exp_words));
      checkOutput("words_left", 64'(exp_data_q.size()), 64'd0);
      checkOutput("busy_after", 64'(busy_o), 64'd0);
      if (vecs[i].exp_words == 0) begin
        checkOutput("zero_reqs", 64'(reqs_seen), 64'd0);
        checkOutput("zero_busy", 64'(busy_seen), 64'd0);
        checkOutput("zero_done_lat", 64'(done_cyc - start_cyc), 64'd0);
      end else begin
        checkOutput("first_addr", first_addr, vecs[i].exp_first);
        checkOutput("first_req_lat", 64'(first_req_cyc - start_cyc), 64'd0);
        checkOutput("valid_lat", 64'(first_valid_cyc - start_cyc), 64'd2);
        checkOutput("done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
        if (vecs[i].mode == 0) begin
          checkOutput("req_span", 64'(last_req_cyc - first_req_cyc), 64'(vecs[i].exp_words - 1));
        end else if (vecs[i].mode == 1) begin
          checkOutput("req_stalled", 64'((last_req_cyc - first_req_cyc) > (vecs[i].exp_words - 1)), 64'd1);
        end
      end
    end

    // Restart while busy: the new base/size must be ignored.
    applyStimulus(64'h5000, 5, 1);
    repeat (2) @(posedge clk_i);
    #2;
    base_addr_i = 64'h9000;
    size_i      = 2;
    start_i     = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    start_i = 1'b0;
    waitDone(400);
    checkOutput("restart_words", 64'(words_seen), 64'd5);
    checkOutput("restart_done", 64'(done_cnt), 64'd1);
    checkOutput("restart_left", 64'(exp_data_q.size()), 64'd0);
    checkOutput("restart_first", first_addr, 64'h5000);

    // Reset in the middle of a transfer, then a fresh short one.
    applyStimulus(64'h6000, 6, 0);
    begin
      int n = 0;
      while (words_seen < 2 && n < 100) begin
        @(posedge clk_i);
        n++;
      end
    end
    checkOutput("pre_reset_words", 64'(words_seen >= 2), 64'd1);
    #2;
    rst_ni = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk_i);
    #2;
    checkReset();
    rst_ni = 1'b1;
    applyStimulus(64'h7000, 2, 0);
    waitDone(400);
    checkOutput("post_reset_words", 64'(words_seen), 64'd2);
    checkOutput("post_reset_done", 64'(done_cnt), 64'd1);
    checkOutput("post_reset_left", 64'(exp_data_q.size()), 64'd0);

`ifdef MEM_STREAM_PERF_CNT_EN
    ready_manual = 1'b0;
    applyStimulus(64'h8000, 3, 3);
    begin
      int n = 0;
      while (!valid_o && n < 50) begin
        @(negedge clk_i);
        n++;
      end
    end
    checkOutput("perf_valid_seen", 64'(valid_o), 64'd1);
    repeat (5) @(posedge clk_i);
    ready_manual = 1'b1;
    waitDone(400);
    checkOutput("perf_words", 64'(words_seen), 64'd3);
    checkOutput("perf_stall", 64'(stall_cycles_o), 64'd5);
    ready_manual = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
